// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: PC-to-imem address, returned instruction, control from
// hazard/execute, and the IF/ID register contents handed to decode.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_ins;
  logic                  id_valid;
  logic [31:0]           id_ins;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pc_plus4;
  logic                  fetch_fault;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_ins,
    output imem_addr, id_valid, id_ins, id_pc, id_pc_plus4, fetch_fault
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_ins,
    input  imem_addr, id_valid, id_ins, id_pc, id_pc_plus4, fetch_fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32IM instruction-fetch stage: PC register, combinational imem address,
// IF/ID pipeline register, stall/redirect handling and sticky misalign halt.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0]           NOP  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  target_misaligned;
  logic                  id_valid;
  logic [31:0]           id_ins;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [ADDR_WIDTH-1:0] id_pc_plus4;
  logic                  fetch_fault;

  // Wraps modulo 2^ADDR_WIDTH by construction; wrapping is not a fault.
  assign pc_plus4          = pc + FOUR;
  assign target_misaligned = |bus.redirect_target[1:0];

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, matching real flop behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_ins      <= NOP;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            // Redirect beats stall; the wrong-path instruction becomes a bubble.
            id_valid <= 1'b0;
            id_ins   <= NOP;
            if (target_misaligned) begin
              fetch_fault <= 1'b1;
              state       <= HALT;
            end else begin
              pc <= bus.redirect_target;
            end
          end else if (!bus.stall) begin
            id_valid    <= 1'b1;
            id_ins      <= bus.imem_ins;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
            pc          <= pc_plus4;
          end
        end
        HALT: begin
          // Sticky until reset; nothing else is fetched.
          id_valid <= 1'b0;
          id_ins   <= NOP;
        end
        default: state <= HALT;
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.id_valid    = id_valid;
  assign bus.id_ins      = id_ins;
  assign bus.id_pc       = id_pc;
  assign bus.id_pc_plus4 = id_pc_plus4;
  assign bus.fetch_fault = fetch_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: the driver pushes hand-computed
// expected observations; a negedge monitor pops and compares them.
module tb_instruction_fetch;

  localparam int AW = 8;

  typedef struct packed {
    logic          valid;
    logic [31:0]   ins;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
    logic          fault;
    logic [AW-1:0] addr;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] mem [64];

  obs_t  exp_q [$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  obs_t  mon_exp;
  obs_t  mon_act;
  string mon_nm;

  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational instruction memory.
  assign bus.imem_ins = mem[bus.imem_addr[7:2]];

  function automatic obs_t mk(input logic v, input logic [31:0] ins,
                              input logic [7:0] pc, input logic [7:0] pc4,
                              input logic f, input logic [7:0] addr);
    obs_t o;
    o.valid = v; o.ins = ins; o.pc = pc; o.pc4 = pc4; o.fault = f; o.addr = addr;
    return o;
  endfunction

  task automatic step(input string nm, input logic rn, input logic st,
                      input logic rv, input logic [7:0] tgt, input obs_t e);
    rst_n               = rn;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares one expected observation per cycle, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = mk(bus.id_valid, bus.id_ins, bus.id_pc, bus.id_pc_plus4,
                   bus.fetch_fault, bus.imem_addr);
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got v=%0b ins=%h pc=%h pc4=%h fault=%0b addr=%h, expected v=%0b ins=%h pc=%h pc4=%h fault=%0b addr=%h",
                 mon_nm, mon_act.valid, mon_act.ins, mon_act.pc, mon_act.pc4,
                 mon_act.fault, mon_act.addr, mon_exp.valid, mon_exp.ins,
                 mon_exp.pc, mon_exp.pc4, mon_exp.fault, mon_exp.addr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Filler words carry their own byte address so they are easy to predict.
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | (i * 4);
    mem[0] = 32'h0050_0193;
    mem[1] = 32'h0070_0213;
    mem[2] = 32'h0100_00EF;

    //   name           rst st rv tgt          v  ins           pc     pc4    f  addr
    step("reset",       0, 0, 0, 8'h00, mk(0, 32'h0000_0013, 8'h00, 8'h00, 0, 8'h00));
    step("fetch0",      1, 0, 0, 8'h00, mk(1, 32'h0050_0193, 8'h00, 8'h04, 0, 8'h04));
    step("fetch4",      1, 0, 0, 8'h00, mk(1, 32'h0070_0213, 8'h04, 8'h08, 0, 8'h08));
    step("stall1",      1, 1, 0, 8'h00, mk(1, 32'h0070_0213, 8'h04, 8'h08, 0, 8'h08));
    step("stall2",      1, 1, 0, 8'h00, mk(1, 32'h0070_0213, 8'h04, 8'h08, 0, 8'h08));
    step("stall3",      1, 1, 0, 8'h00, mk(1, 32'h0070_0213, 8'h04, 8'h08, 0, 8'h08));
    step("fetch8",      1, 0, 0, 8'h00, mk(1, 32'h0100_00EF, 8'h08, 8'h0C, 0, 8'h0C));
    step("fetchC",      1, 0, 0, 8'h00, mk(1, 32'h1000_000C, 8'h0C, 8'h10, 0, 8'h10));
    step("redir18",     1, 0, 1, 8'h18, mk(0, 32'h0000_0013, 8'h0C, 8'h10, 0, 8'h18));
    step("fetch18",     1, 0, 0, 8'h00, mk(1, 32'h1000_0018, 8'h18, 8'h1C, 0, 8'h1C));
    step("redir10_stl", 1, 1, 1, 8'h10, mk(0, 32'h0000_0013, 8'h18, 8'h1C, 0, 8'h10));
    step("stall_bub",   1, 1, 0, 8'h00, mk(0, 32'h0000_0013, 8'h18, 8'h1C, 0, 8'h10));
    step("fetch10",     1, 0, 0, 8'h00, mk(1, 32'h1000_0010, 8'h10, 8'h14, 0, 8'h14));
    step("misalign1A",  1, 0, 1, 8'h1A, mk(0, 32'h0000_0013, 8'h10, 8'h14, 1, 8'h14));
    step("halt_run",    1, 0, 0, 8'h00, mk(0, 32'h0000_0013, 8'h10, 8'h14, 1, 8'h14));
    step("halt_redir",  1, 0, 1, 8'h20, mk(0, 32'h0000_0013, 8'h10, 8'h14, 1, 8'h14));
    step("rst_mid",     0, 1, 1, 8'h20, mk(0, 32'h0000_0013, 8'h00, 8'h00, 0, 8'h00));
    step("refetch0",    1, 0, 0, 8'h00, mk(1, 32'h0050_0193, 8'h00, 8'h04, 0, 8'h04));
    step("redirF8",     1, 0, 1, 8'hF8, mk(0, 32'h0000_0013, 8'h00, 8'h04, 0, 8'hF8));
    step("fetchF8",     1, 0, 0, 8'h00, mk(1, 32'h1000_00F8, 8'hF8, 8'hFC, 0, 8'hFC));
    step("fetchFC",     1, 0, 0, 8'h00, mk(1, 32'h1000_00FC, 8'hFC, 8'h00, 0, 8'h00));
    step("wrap0",       1, 0, 0, 8'h00, mk(1, 32'h0050_0193, 8'h00, 8'h04, 0, 8'h04));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected entries left unchecked, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
